frame_err_check: RTL

Parametrised frame-error checker for the UART RX path. It generalises the single stop-bit check into one block that handles:
- parity check (even/odd/off) and one or two stop bits;
- frame sequencing, with a frame-done strobe and frame-OK status;
- saturating error counters and sticky error flags with clear.

It sits beside the RX FSM, consuming the sampler's sampled_bit, the edge counter and the deserialiser's P_DATA.

---
 rtl/frame_err_check.sv | 126 ++++++++++++
 1 files changed

// File: rtl/frame_err_check.sv
// Frame-error checker for the UART RX path: parity and one/two stop-bit checks,
// frame-done/frame-OK status, saturating error counters and sticky error flags.
module frame_err_check #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 6,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   frame_start,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic                   STOP2,
    input  logic [PRESC_WIDTH-1:0] Prescale,
    input  logic [PRESC_WIDTH-1:0] edge_cnt,
    input  logic                   sampled_bit,
    input  logic                   par_chk_en,
    input  logic                   stp_chk_en,
    input  logic [DATA_WIDTH-1:0]  P_DATA,
    input  logic                   err_clr,
    output logic                   par_err,
    output logic                   stp_err,
    output logic                   frame_done,
    output logic                   frame_ok,
    output logic [1:0]             err_sticky,
    output logic [CNT_WIDTH-1:0]   par_err_cnt,
    output logic [CNT_WIDTH-1:0]   stp_err_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT_PAR, WAIT_STP1, WAIT_STP2} state_t;

    state_t r_state;
    logic   r_par_typ;
    logic   r_stop2;
    logic   r_match_prev;

    logic [PRESC_WIDTH-1:0] w_chk;
    logic                   w_en;
    logic                   w_match;
    logic                   w_strobe;
    logic                   w_done;
    logic                   w_fin_stp;
    logic                   w_par_calc;

    assign w_chk = (Prescale >> 1) + PRESC_WIDTH'(2);

    always_comb begin
        w_en = 1'b0;
        case (r_state)
            WAIT_PAR:             w_en = par_chk_en;
            WAIT_STP1, WAIT_STP2: w_en = stp_chk_en;
            default:              w_en = 1'b0;
        endcase
    end

    // Only the first cycle of a match counts, so a held edge_cnt checks once.
    assign w_match    = w_en && (edge_cnt == w_chk);
    assign w_strobe   = w_match && !r_match_prev;
    assign w_par_calc = sampled_bit ^ (^P_DATA) ^ r_par_typ;
    assign w_fin_stp  = ((r_state == WAIT_STP2) && stp_err) || !sampled_bit;
    assign w_done     = !frame_start && w_strobe &&
                        (((r_state == WAIT_STP1) && !r_stop2) || (r_state == WAIT_STP2));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= IDLE;
            r_par_typ    <= 1'b0;
            r_stop2      <= 1'b0;
            r_match_prev <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
            frame_done   <= 1'b0;
            frame_ok     <= 1'b0;
        end else begin
            r_match_prev <= w_match;
            frame_done   <= 1'b0;
            if (frame_start) begin
                r_par_typ <= PAR_TYP;
                r_stop2   <= STOP2;
                par_err   <= 1'b0;
                stp_err   <= 1'b0;
                r_state   <= PAR_EN ? WAIT_PAR : WAIT_STP1;
            end else if (w_strobe) begin
                case (r_state)
                    WAIT_PAR: begin
                        par_err <= w_par_calc;
                        r_state <= WAIT_STP1;
                    end
                    WAIT_STP1: begin
                        stp_err <= w_fin_stp;
                        r_state <= r_stop2 ? WAIT_STP2 : IDLE;
                    end
                    WAIT_STP2: begin
                        stp_err <= w_fin_stp;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
                if (w_done) begin
                    frame_done <= 1'b1;
                    frame_ok   <= !par_err && !w_fin_stp;
                end
            end
        end
    end

    // err_clr takes priority over an increment or sticky set on the same edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
            err_sticky  <= 2'b00;
        end else if (err_clr) begin
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
            err_sticky  <= 2'b00;
        end else if (w_done) begin
            if (par_err && !(&par_err_cnt))
                par_err_cnt <= par_err_cnt + CNT_WIDTH'(1);
            if (w_fin_stp && !(&stp_err_cnt))
                stp_err_cnt <= stp_err_cnt + CNT_WIDTH'(1);
            err_sticky <= err_sticky | {w_fin_stp, par_err};
        end
    end

endmodule
